// File: rtl/sa_seq_ctrl_pkg.sv
// Shared types, default sizes and latency helper for the systolic-array sequencer.
// Optional feature macro used by the top: SA_SEQ_CTRL_PERF_EN.
package sa_seq_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_STREAM = 2'd2,
        ST_DRAIN  = 2'd3
    } seq_state_t;

    localparam int DEF_ROWS    = 8;
    localparam int DEF_COLS    = 8;
    localparam int DEF_PE_LAT  = 3;
    localparam int DEF_ACT_HOP = 4;
    localparam int DEF_VEC_W   = 10;

    // Operand / accumulator widths mirrored from the array config header.
    localparam int DATASIZE            = 8;
    localparam int OUTPUT_BUF_DATASIZE = 32;

    // Cycles from row 0 issuing a vector to column col's result leaving the array bottom.
    function automatic int cap_lat(input int rows, input int pe_lat, input int act_hop, input int col);
        return 1 + (rows - 1) * pe_lat + col * act_hop + pe_lat;
    endfunction

endpackage

// File: rtl/sa_skew_line.sv
// Valid + vector-index delay line; pending flags any entry not yet at the output stage.
module sa_skew_line #(
    parameter int DEPTH = 1,
    parameter int IDX_W = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [IDX_W-1:0] in_idx,
    output logic             out_valid,
    output logic [IDX_W-1:0] out_idx,
    output logic             pending
);

    generate
        if (DEPTH == 0) begin : g_wire
            wire unused_clk_rst = clk ^ rst;
            assign out_valid = in_valid;
            assign out_idx   = in_idx;
            assign pending   = 1'b0;
        end else begin : g_shift
            logic             valid_reg [DEPTH];
            logic [IDX_W-1:0] idx_reg   [DEPTH];

            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        valid_reg[i] <= 1'b0;
                        idx_reg[i]   <= '0;
                    end
                end else begin
                    valid_reg[0] <= in_valid;
                    idx_reg[0]   <= in_idx;
                    for (int i = 1; i < DEPTH; i++) begin
                        valid_reg[i] <= valid_reg[i-1];
                        idx_reg[i]   <= idx_reg[i-1];
                    end
                end
            end

            // The last stage drains on the next edge by itself, so it is left out.
            always_comb begin
                pending = 1'b0;
                for (int i = 0; i < DEPTH - 1; i++) begin
                    pending = pending | valid_reg[i];
                end
            end

            assign out_valid = valid_reg[DEPTH-1];
            assign out_idx   = idx_reg[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/sa_seq_ctrl.sv
// Weight-stationary systolic array sequencer: weight preload, skewed activation issue, output capture.
// Define SA_SEQ_CTRL_PERF_EN to add the perf_cycles / perf_jobs counters.
module sa_seq_ctrl
    import sa_seq_ctrl_pkg::*;
#(
    parameter int ROWS    = DEF_ROWS,
    parameter int COLS    = DEF_COLS,
    parameter int PE_LAT  = DEF_PE_LAT,
    parameter int ACT_HOP = DEF_ACT_HOP,
    parameter int VEC_W   = DEF_VEC_W,
    localparam int WA_W   = (ROWS > 1) ? $clog2(ROWS) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [VEC_W-1:0]        num_vec,
    output logic                    busy,
    output logic                    done,
    output logic                    wbuf_rd_en,
    output logic [WA_W-1:0]         wbuf_rd_addr,
    output logic                    write_weight_en,
    output logic [ROWS-1:0]         abuf_rd_en,
    output logic [ROWS*VEC_W-1:0]   abuf_rd_addr,
    output logic [COLS-1:0]         obuf_wr_en,
    output logic [COLS*VEC_W-1:0]   obuf_wr_addr
`ifdef SA_SEQ_CTRL_PERF_EN
    ,
    output logic [31:0]             perf_cycles,
    output logic [15:0]             perf_jobs
`endif
);

    localparam int LC_W = $clog2(ROWS + 2);

    seq_state_t       state_reg;
    logic [VEC_W-1:0] nvec_reg;
    logic [LC_W-1:0]  lcnt_reg;
    logic             issue_reg;
    logic [VEC_W-1:0] issue_idx_reg;
    logic             busy_reg;
    logic             done_reg;
    logic             wbuf_rd_en_reg;
    logic [WA_W-1:0]  wbuf_rd_addr_reg;
    logic             wwe_reg;

    logic [ROWS-1:0]  row_pending;
    logic [COLS-1:0]  col_pending;
    logic             drain_empty;
    logic             finish_now;

    assign drain_empty = !issue_reg && !(|row_pending) && !(|col_pending);
    assign finish_now  = (state_reg == ST_DRAIN) && !done_reg && drain_empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg        <= ST_IDLE;
            nvec_reg         <= '0;
            lcnt_reg         <= '0;
            issue_reg        <= 1'b0;
            issue_idx_reg    <= '0;
            busy_reg         <= 1'b0;
            done_reg         <= 1'b0;
            wbuf_rd_en_reg   <= 1'b0;
            wbuf_rd_addr_reg <= '0;
            wwe_reg          <= 1'b0;
        end else begin
            // Weight buffer has one cycle of read latency.
            wwe_reg <= wbuf_rd_en_reg;
            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        state_reg        <= ST_LOAD;
                        busy_reg         <= 1'b1;
                        nvec_reg         <= num_vec;
                        lcnt_reg         <= '0;
                        wbuf_rd_en_reg   <= 1'b1;
                        wbuf_rd_addr_reg <= WA_W'(ROWS - 1);
                    end
                end
                ST_LOAD: begin
                    lcnt_reg <= lcnt_reg + LC_W'(1);
                    if (int'(lcnt_reg) < ROWS - 1) begin
                        wbuf_rd_en_reg   <= 1'b1;
                        wbuf_rd_addr_reg <= WA_W'(ROWS - 2 - int'(lcnt_reg));
                    end else begin
                        wbuf_rd_en_reg   <= 1'b0;
                        wbuf_rd_addr_reg <= '0;
                    end
                    // An empty job still spends one DRAIN cycle so done lands at t0+ROWS+3.
                    if (int'(lcnt_reg) == ROWS) begin
                        if (nvec_reg == '0) begin
                            state_reg <= ST_DRAIN;
                        end else begin
                            state_reg     <= ST_STREAM;
                            issue_reg     <= 1'b1;
                            issue_idx_reg <= '0;
                        end
                    end
                end
                ST_STREAM: begin
                    if (issue_idx_reg == nvec_reg - VEC_W'(1)) begin
                        issue_reg <= 1'b0;
                        state_reg <= ST_DRAIN;
                    end else begin
                        issue_idx_reg <= issue_idx_reg + VEC_W'(1);
                    end
                end
                ST_DRAIN: begin
                    if (done_reg) begin
                        done_reg  <= 1'b0;
                        busy_reg  <= 1'b0;
                        state_reg <= ST_IDLE;
                    end else if (drain_empty) begin
                        done_reg <= 1'b1;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < ROWS; gi++) begin : g_row
            sa_skew_line #(
                .DEPTH (gi * PE_LAT),
                .IDX_W (VEC_W)
            ) u_row_line (
                .clk       (clk),
                .rst       (rst),
                .in_valid  (issue_reg),
                .in_idx    (issue_idx_reg),
                .out_valid (abuf_rd_en[gi]),
                .out_idx   (abuf_rd_addr[gi*VEC_W +: VEC_W]),
                .pending   (row_pending[gi])
            );
        end
        for (gi = 0; gi < COLS; gi++) begin : g_col
            sa_skew_line #(
                .DEPTH (cap_lat(ROWS, PE_LAT, ACT_HOP, gi)),
                .IDX_W (VEC_W)
            ) u_col_line (
                .clk       (clk),
                .rst       (rst),
                .in_valid  (issue_reg),
                .in_idx    (issue_idx_reg),
                .out_valid (obuf_wr_en[gi]),
                .out_idx   (obuf_wr_addr[gi*VEC_W +: VEC_W]),
                .pending   (col_pending[gi])
            );
        end
    endgenerate

    assign busy            = busy_reg;
    assign done            = done_reg;
    assign wbuf_rd_en      = wbuf_rd_en_reg;
    assign wbuf_rd_addr    = wbuf_rd_addr_reg;
    assign write_weight_en = wwe_reg;

`ifdef SA_SEQ_CTRL_PERF_EN
    logic [31:0] run_cycles_reg;
    logic [31:0] perf_cycles_reg;
    logic [15:0] perf_jobs_reg;

    // Results are published on the done edge and then held until the next job completes.
    always_ff @(posedge clk) begin
        if (rst) begin
            run_cycles_reg  <= '0;
            perf_cycles_reg <= '0;
            perf_jobs_reg   <= '0;
        end else begin
            if (state_reg == ST_IDLE && start) begin
                run_cycles_reg <= 32'd1;
            end else if (busy_reg) begin
                run_cycles_reg <= run_cycles_reg + 32'd1;
            end
            if (finish_now) begin
                perf_cycles_reg <= run_cycles_reg + 32'd1;
                perf_jobs_reg   <= perf_jobs_reg + 16'd1;
            end
        end
    end

    assign perf_cycles = perf_cycles_reg;
    assign perf_jobs   = perf_jobs_reg;
`endif

endmodule

// File: tb/tb_sa_seq_ctrl.sv
// Scoreboard bench for sa_seq_ctrl: timing model from the job formulas plus an identity-weight array model.
// Perf counters are checked when SA_SEQ_CTRL_PERF_EN is defined.
module tb_sa_seq_ctrl;

    localparam int ROWS    = 4;
    localparam int COLS    = 4;
    localparam int PE_LAT  = 3;
    localparam int ACT_HOP = 4;
    localparam int VEC_W   = 10;
    localparam int WA_W    = 2;
    localparam int HIST    = 4096;
    localparam int AMEM    = 16;

    localparam int K_WBUF = 0;
    localparam int K_WWE  = 1;
    localparam int K_ABUF = 2;
    localparam int K_OBUF = 3;
    localparam int K_DONE = 4;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  start;
    logic [VEC_W-1:0]      num_vec;
    logic                  busy;
    logic                  done;
    logic                  wbuf_rd_en;
    logic [WA_W-1:0]       wbuf_rd_addr;
    logic                  write_weight_en;
    logic [ROWS-1:0]       abuf_rd_en;
    logic [ROWS*VEC_W-1:0] abuf_rd_addr;
    logic [COLS-1:0]       obuf_wr_en;
    logic [COLS*VEC_W-1:0] obuf_wr_addr;
`ifdef SA_SEQ_CTRL_PERF_EN
    logic [31:0]           perf_cycles;
    logic [15:0]           perf_jobs;
`endif

    sa_seq_ctrl #(
        .ROWS    (ROWS),
        .COLS    (COLS),
        .PE_LAT  (PE_LAT),
        .ACT_HOP (ACT_HOP),
        .VEC_W   (VEC_W)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .num_vec         (num_vec),
        .busy            (busy),
        .done            (done),
        .wbuf_rd_en      (wbuf_rd_en),
        .wbuf_rd_addr    (wbuf_rd_addr),
        .write_weight_en (write_weight_en),
        .abuf_rd_en      (abuf_rd_en),
        .abuf_rd_addr    (abuf_rd_addr),
        .obuf_wr_en      (obuf_wr_en),
        .obuf_wr_addr    (obuf_wr_addr)
`ifdef SA_SEQ_CTRL_PERF_EN
        ,
        .perf_cycles     (perf_cycles),
        .perf_jobs       (perf_jobs)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    typedef struct {
        int kind;
        int lane;
        int cyc;
        int val;
    } ev_t;

    ev_t exp_q[$];
    int  total = 0;
    int  bad = 0;
    int  busy_from = -1;
    int  busy_to = -2;
    int  jobs_model = 0;

    int act_mem  [ROWS][AMEM];
    int hist_val [ROWS][HIST];
    int hist_cyc [ROWS][HIST];
    int wt       [ROWS][COLS];
    int last_rd_addr = -1;
    int last_rd_cyc = -10;

    function automatic int cap(input int c);
        return 1 + (ROWS - 1) * PE_LAT + c * ACT_HOP + PE_LAT;
    endfunction

    function automatic void push_ev(input int k, input int l, input int c, input int v);
        ev_t e;
        e.kind = k;
        e.lane = l;
        e.cyc  = c;
        e.val  = v;
        exp_q.push_back(e);
    endfunction

    // Expected strobe schedule of one accepted job, straight from the job timing rules.
    function automatic void model_job(input int t0, input int n);
        int len;
        len = (n == 0) ? ROWS + 3
                       : ROWS + 2 + n + (ROWS - 1) * PE_LAT + (COLS - 1) * ACT_HOP + PE_LAT + 1;
        busy_from = t0 + 1;
        busy_to   = t0 + len;
        for (int i = 0; i < ROWS; i++) begin
            push_ev(K_WBUF, 0, t0 + 1 + i, ROWS - 1 - i);
            push_ev(K_WWE, 0, t0 + 2 + i, 0);
        end
        for (int k = 0; k < n; k++) begin
            for (int r = 0; r < ROWS; r++) push_ev(K_ABUF, r, t0 + ROWS + 2 + k + r * PE_LAT, k);
            for (int c = 0; c < COLS; c++) push_ev(K_OBUF, c, t0 + ROWS + 2 + k + cap(c), k);
        end
        push_ev(K_DONE, 0, t0 + len, len);
        $display("job: start cycle %0d num_vec=%0d expected done cycle %0d", t0, n, t0 + len);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue_start(input int n);
        start   = 1'b1;
        num_vec = VEC_W'(n);
        if (cyc > busy_to) model_job(cyc, n);
        else $display("start pulse at cycle %0d while busy (num_vec=%0d), expect ignore", cyc, n);
        tick();
        start   = 1'b0;
        num_vec = VEC_W'($urandom);
    endtask

    task automatic wait_idle();
        int guard;
        guard = 0;
        while (cyc <= busy_to && guard < 2000) begin
            tick();
            guard++;
        end
        if (guard >= 2000) begin
            total++;
            bad++;
            $display("FAIL wait_idle: timeout at cycle %0d, job end model %0d", cyc, busy_to);
        end
    endtask

    task automatic apply_reset_now();
        rst = 1'b1;
        for (int i = exp_q.size() - 1; i >= 0; i--) begin
            if (exp_q[i].cyc > cyc) exp_q.delete(i);
        end
        if (busy_to > cyc) busy_to = cyc;
        jobs_model = 0;
        $display("reset asserted during cycle %0d", cyc);
        tick();
        rst = 1'b0;
    endtask

    task automatic check_strobe(input int k, input int l, input int v, input string nm,
                                output bit found, output int expv);
        int idx;
        idx   = -1;
        found = 1'b0;
        expv  = 0;
        for (int i = 0; i < exp_q.size(); i++) begin
            if (exp_q[i].kind == k && exp_q[i].lane == l && exp_q[i].cyc == cyc) begin
                idx = i;
                break;
            end
        end
        total++;
        if (idx < 0) begin
            bad++;
            $display("FAIL %s lane %0d: unexpected strobe at cycle %0d (addr %0d), required none", nm, l, cyc, v);
        end else begin
            found = 1'b1;
            expv  = exp_q[idx].val;
            if ((k == K_WBUF || k == K_ABUF || k == K_OBUF) && exp_q[idx].val != v) begin
                bad++;
                $display("FAIL %s lane %0d cycle %0d: addr got %0d required %0d", nm, l, cyc, v, exp_q[idx].val);
            end
            exp_q.delete(idx);
        end
    endtask

    always @(negedge clk) begin
        bit  exp_busy;
        bit  found;
        int  expv;
        int  a;
        int  sum;
        int  tr;
        exp_busy = (cyc >= busy_from) && (cyc <= busy_to);
        total++;
        if (busy !== exp_busy) begin
            bad++;
            $display("FAIL busy cycle %0d: got %b required %b", cyc, busy, exp_busy);
        end
        // Weights shift down the column; the word comes from the previous cycle's read.
        if (write_weight_en === 1'b1) begin
            check_strobe(K_WWE, 0, 0, "write_weight_en", found, expv);
            for (int r = ROWS - 1; r > 0; r--) for (int c = 0; c < COLS; c++) wt[r][c] = wt[r-1][c];
            for (int c = 0; c < COLS; c++)
                wt[0][c] = (last_rd_cyc == cyc - 1 && last_rd_addr == c) ? 1 : 0;
        end
        if (wbuf_rd_en === 1'b1) begin
            check_strobe(K_WBUF, 0, int'(wbuf_rd_addr), "wbuf_rd", found, expv);
            last_rd_addr = int'(wbuf_rd_addr);
            last_rd_cyc  = cyc;
        end
        for (int r = 0; r < ROWS; r++) begin
            if (abuf_rd_en[r] === 1'b1) begin
                a = int'(abuf_rd_addr[r*VEC_W +: VEC_W]);
                check_strobe(K_ABUF, r, a, "abuf_rd", found, expv);
                hist_val[r][cyc % HIST] = act_mem[r][a % AMEM];
                hist_cyc[r][cyc % HIST] = cyc;
            end
        end
        for (int c = 0; c < COLS; c++) begin
            if (obuf_wr_en[c] === 1'b1) begin
                a = int'(obuf_wr_addr[c*VEC_W +: VEC_W]);
                check_strobe(K_OBUF, c, a, "obuf_wr", found, expv);
                sum = 0;
                for (int r = 0; r < ROWS; r++) begin
                    tr = cyc - (cap(c) - r * PE_LAT);
                    if (tr >= 0 && hist_cyc[r][tr % HIST] == tr) sum += wt[r][c] * hist_val[r][tr % HIST];
                end
                total++;
                if (sum != act_mem[c][a % AMEM]) begin
                    bad++;
                    $display("FAIL obuf_data col %0d cycle %0d addr %0d: got %0d required %0d",
                             c, cyc, a, sum, act_mem[c][a % AMEM]);
                end
            end
        end
        if (done === 1'b1) begin
            check_strobe(K_DONE, 0, 0, "done", found, expv);
            $display("done observed at cycle %0d", cyc);
`ifdef SA_SEQ_CTRL_PERF_EN
            if (found) begin
                jobs_model++;
                total++;
                if (int'(perf_cycles) != expv) begin
                    bad++;
                    $display("FAIL perf_cycles cycle %0d: got %0d required %0d", cyc, perf_cycles, expv);
                end
                total++;
                if (int'(perf_jobs) != (jobs_model % 65536)) begin
                    bad++;
                    $display("FAIL perf_jobs cycle %0d: got %0d required %0d", cyc, perf_jobs, jobs_model % 65536);
                end
            end
`endif
        end
        for (int i = exp_q.size() - 1; i >= 0; i--) begin
            if (exp_q[i].cyc <= cyc) begin
                total++;
                bad++;
                $display("FAIL missing kind %0d lane %0d: no strobe at cycle %0d (addr %0d)",
                         exp_q[i].kind, exp_q[i].lane, exp_q[i].cyc, exp_q[i].val);
                exp_q.delete(i);
            end
        end
    end

    task automatic check_idle_outputs(input string nm);
        total++;
        if ({wbuf_rd_en, write_weight_en, abuf_rd_en, obuf_wr_en, done} !== '0 ||
            abuf_rd_addr !== '0 || obuf_wr_addr !== '0 || wbuf_rd_addr !== '0) begin
            bad++;
            $display("FAIL %s cycle %0d: strobes=%b abuf_addr=%h obuf_addr=%h wbuf_addr=%0d required all 0",
                     nm, cyc, {wbuf_rd_en, write_weight_en, abuf_rd_en, obuf_wr_en, done},
                     abuf_rd_addr, obuf_wr_addr, wbuf_rd_addr);
        end
    endtask

    initial begin
        int t0;
        int n;
        rst     = 1'b1;
        start   = 1'b0;
        num_vec = '0;
        for (int r = 0; r < ROWS; r++) begin
            for (int a = 0; a < AMEM; a++) act_mem[r][a] = int'($urandom_range(1, 255));
            for (int h = 0; h < HIST; h++) begin
                hist_val[r][h] = 0;
                hist_cyc[r][h] = -1;
            end
            for (int c = 0; c < COLS; c++) wt[r][c] = 0;
        end
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_idle_outputs("reset_state");
`ifdef SA_SEQ_CTRL_PERF_EN
        total++;
        if (perf_cycles !== 32'd0 || perf_jobs !== 16'd0) begin
            bad++;
            $display("FAIL perf_reset: got %0d/%0d required 0/0", perf_cycles, perf_jobs);
        end
`endif

        // Reference job: start at cycle 10, one vector, done expected at 42.
        while (cyc < 10) tick();
        issue_start(1);
        wait_idle();

        issue_start(0);
        wait_idle();

        issue_start(5);
        wait_idle();

        // Start re-pulsed while busy must be ignored.
        issue_start(3);
        repeat (6) tick();
        issue_start(7);
        wait_idle();

        // Reset while row 0 issues vector 2.
        repeat (2) tick();
        t0 = cyc;
        issue_start(6);
        while (cyc < t0 + ROWS + 4) tick();
        apply_reset_now();
        @(negedge clk);
        check_idle_outputs("post_reset_strobes");
        repeat (3) tick();
        issue_start(4);
        wait_idle();

        // Back-to-back: wait_idle returns in the cycle after done.
        issue_start(3);
        wait_idle();
        issue_start(3);
        wait_idle();

        repeat (10) begin
            n = int'($urandom_range(0, 12));
            repeat ($urandom_range(0, 3)) tick();
            issue_start(n);
            if ($urandom_range(0, 1) == 1) begin
                repeat ($urandom_range(1, 5)) tick();
                issue_start(int'($urandom_range(0, 12)));
            end
            wait_idle();
        end

        repeat (5) tick();
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL leftover_events: got %0d pending required 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
